// File: rtl/io_request_arbiter_pkg.sv
// Shared types for the non-cached I/O request arbiter: request/response
// packets, arbiter FSM states and the sizing helper for grant indices.
package io_request_arbiter_pkg;

  localparam int NUM_CORES        = 4;
  localparam int CORE_ID_W        = 4;   // wide enough for up to 16 requesters
  localparam int THREAD_IDX_W     = 2;

  typedef logic [CORE_ID_W-1:0]    core_id_t;
  typedef logic [THREAD_IDX_W-1:0] local_thread_idx_t;

  typedef struct packed {
    logic              is_store;
    logic [31:0]       address;
    logic [31:0]       value;
    local_thread_idx_t thread_idx;
  } ioreq_packet_t;

  typedef struct packed {
    core_id_t          core;
    local_thread_idx_t thread_idx;
    logic [31:0]       read_value;
  } iorsp_packet_t;

  typedef enum logic [1:0] {
    IO_ARB_IDLE,
    IO_ARB_ISSUE,
    IO_ARB_CAPTURE,
    IO_ARB_RESPOND
  } io_arb_state_t;

  // Index width for a vector of n requesters (never zero).
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_request_arbiter_if.sv
// Single non-cached peripheral register bus. The arbiter is the master;
// read_data is returned by the slave one cycle after read_en.
interface io_bus_interface;

  logic        write_en;
  logic        read_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output write_en,
    output read_en,
    output address,
    output write_data,
    input  read_data
  );

  modport slave (
    input  write_en,
    input  read_en,
    input  address,
    input  write_data,
    output read_data
  );

endinterface

// File: rtl/io_request_arbiter_grant_select.sv
// Grant selection for the I/O arbiter. With IO_ARB_ROUND_ROBIN_EN defined the
// lowest valid index at or after an internal pointer wins and the pointer
// moves past each accepted grant; otherwise the lowest valid index wins and
// no pointer state exists.
module io_grant_select
  import io_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = NUM_CORES,
  localparam int IDX_W = idx_width(NUM_REQUESTERS)
) (
`ifdef IO_ARB_ROUND_ROBIN_EN
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      advance,
`endif
  input  logic [NUM_REQUESTERS-1:0] valid,
  output logic [NUM_REQUESTERS-1:0] grant_oh,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      any_valid
);

  assign any_valid = |valid;

`ifdef IO_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   cand;
  logic             found;

  // Rotating search starting at the pointer; first valid requester wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQUESTERS)) begin
        cand = cand - (IDX_W+1)'(NUM_REQUESTERS);
      end
      if (!found && valid[cand[IDX_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
    grant_oh[grant_idx] = found;
  end

  // Pointer moves to grant+1 (wrapping) whenever a grant is accepted.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == IDX_W'(NUM_REQUESTERS-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  // Fixed priority: lowest valid index wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    for (int i = NUM_REQUESTERS-1; i >= 0; i--) begin
      if (valid[i]) grant_idx = IDX_W'(i);
    end
    grant_oh[grant_idx] = any_valid;
  end
`endif

endmodule

// File: rtl/io_request_arbiter.sv
// Shares the single non-cached I/O bus among all cores. One transaction at a
// time: accept (IDLE) -> bus enable (ISSUE) -> capture read data (CAPTURE,
// loads only) -> single-cycle response pulse (RESPOND).
// Arbitration policy selected by IO_ARB_ROUND_ROBIN_EN (fixed priority when
// undefined).
module io_request_arbiter
  import io_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = NUM_CORES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] ior_request_valid,
  input  ioreq_packet_t             ior_request [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0] ia_ready,
  output logic                      ia_response_valid,
  output iorsp_packet_t             ia_response,
  io_bus_interface.master           io_bus
);

  localparam int IDX_W = idx_width(NUM_REQUESTERS);

  io_arb_state_t       state_q, state_d;
  ioreq_packet_t       req_q, req_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic                write_en_q, write_en_d;
  logic                read_en_q, read_en_d;
  logic                rsp_valid_q, rsp_valid_d;
  iorsp_packet_t       rsp_q, rsp_d;

  logic [NUM_REQUESTERS-1:0] grant_oh;
  logic [IDX_W-1:0]          grant_idx;
  logic                      any_valid;

  io_grant_select #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_grant_select (
`ifdef IO_ARB_ROUND_ROBIN_EN
    .clk       (clk),
    .reset     (reset),
    .advance   ((state_q == IO_ARB_IDLE) && any_valid),
`endif
    .valid     (ior_request_valid),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // The only combinational output: accept pulse to the winning requester.
  assign ia_ready = (state_q == IO_ARB_IDLE && !reset) ? grant_oh : '0;

  assign ia_response_valid  = rsp_valid_q;
  assign ia_response        = rsp_q;
  assign io_bus.write_en    = write_en_q;
  assign io_bus.read_en     = read_en_q;
  assign io_bus.address     = req_q.address;
  assign io_bus.write_data  = req_q.value;

  // Next-state and next-output logic; enables and response are one-cycle pulses.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    grant_d     = grant_q;
    write_en_d  = 1'b0;
    read_en_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_d       = rsp_q;
    case (state_q)
      IO_ARB_IDLE: begin
        if (any_valid) begin
          req_d      = ior_request[grant_idx];
          grant_d    = grant_idx;
          write_en_d = ior_request[grant_idx].is_store;
          read_en_d  = !ior_request[grant_idx].is_store;
          state_d    = IO_ARB_ISSUE;
        end
      end
      IO_ARB_ISSUE: begin
        if (req_q.is_store) begin
          rsp_valid_d      = 1'b1;
          rsp_d.core       = core_id_t'(grant_q);
          rsp_d.thread_idx = req_q.thread_idx;
          rsp_d.read_value = 32'h0;
          state_d          = IO_ARB_RESPOND;
        end else begin
          state_d = IO_ARB_CAPTURE;
        end
      end
      IO_ARB_CAPTURE: begin
        rsp_valid_d      = 1'b1;
        rsp_d.core       = core_id_t'(grant_q);
        rsp_d.thread_idx = req_q.thread_idx;
        rsp_d.read_value = io_bus.read_data;
        state_d          = IO_ARB_RESPOND;
      end
      IO_ARB_RESPOND: begin
        state_d = IO_ARB_IDLE;
      end
      default: begin
        state_d = IO_ARB_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IO_ARB_IDLE;
      req_q       <= '0;
      grant_q     <= '0;
      write_en_q  <= 1'b0;
      read_en_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      grant_q     <= grant_d;
      write_en_q  <= write_en_d;
      read_en_q   <= read_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

endmodule

// File: tb/tb_io_request_arbiter.sv
// Directed bench for io_request_arbiter with a grant/response scoreboard and
// a simple bus slave that returns read data one cycle after read_en.
`timescale 1ns/1ps
module tb_io_request_arbiter;
  import io_request_arbiter_pkg::*;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        ior_request_valid;
  ioreq_packet_t       ior_request [N];
  logic [N-1:0]        ia_ready;
  logic                ia_response_valid;
  iorsp_packet_t       ia_response;

  io_bus_interface io_bus ();

  io_request_arbiter #(.NUM_REQUESTERS(N)) dut (
    .clk               (clk),
    .reset             (reset),
    .ior_request_valid (ior_request_valid),
    .ior_request       (ior_request),
    .ia_ready          (ia_ready),
    .ia_response_valid (ia_response_valid),
    .ia_response       (ia_response),
    .io_bus            (io_bus)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            accept_count = 0;
  bit            hold_mode = 1'b0;
  int            exp_grant_q[$];
  iorsp_packet_t exp_rsp_q[$];
  int            acc_log[$];
  int            rsp_log[$];
  int            rd_log[$];
  int            wr_log[$];
  logic [31:0]   rd_addr_last, wr_addr_last, wr_data_last;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rdata(logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // One clock: sample at negedge, scoreboard grants/responses, log bus
  // activity, then update inputs just after the rising edge.
  task automatic cycle();
    logic [N-1:0] accepted;
    logic [31:0]  next_rd;
    int           g;
    iorsp_packet_t e;
    @(negedge clk);
    accepted = '0;
    check("bus_excl", 64'(io_bus.write_en & io_bus.read_en), 64'd0);
    if (ia_ready != '0) begin
      if (exp_grant_q.size() == 0) begin
        check("unexpected_accept", 64'(ia_ready), 64'd0);
      end else begin
        g = exp_grant_q.pop_front();
        check("grant", 64'(ia_ready), 64'd1 << g);
      end
      accepted = ia_ready;
      acc_log.push_back(cyc);
      accept_count++;
    end
    if (ia_response_valid) begin
      if (exp_rsp_q.size() == 0) begin
        check("unexpected_rsp", 64'(ia_response_valid), 64'd0);
      end else begin
        e = exp_rsp_q.pop_front();
        check("rsp", 64'(ia_response), 64'(e));
      end
      rsp_log.push_back(cyc);
    end
    if (io_bus.read_en) begin
      rd_log.push_back(cyc);
      rd_addr_last = io_bus.address;
    end
    if (io_bus.write_en) begin
      wr_log.push_back(cyc);
      wr_addr_last = io_bus.address;
      wr_data_last = io_bus.write_data;
    end
    next_rd = io_bus.read_en ? model_rdata(io_bus.address) : 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    cyc++;
    if (!hold_mode) ior_request_valid = ior_request_valid & ~accepted;
    io_bus.read_data = next_rd;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    rsp_log.delete();
    rd_log.delete();
    wr_log.delete();
    accept_count = 0;
  endtask

  task automatic request(int core, bit st, logic [31:0] addr, logic [31:0] data, logic [1:0] th);
    ior_request[core].is_store   = st;
    ior_request[core].address    = addr;
    ior_request[core].value      = data;
    ior_request[core].thread_idx = th;
    ior_request_valid[core]      = 1'b1;
  endtask

  task automatic expect_txn(int core);
    iorsp_packet_t e;
    e.core       = core_id_t'(core);
    e.thread_idx = ior_request[core].thread_idx;
    e.read_value = ior_request[core].is_store ? 32'h0 : model_rdata(ior_request[core].address);
    exp_grant_q.push_back(core);
    exp_rsp_q.push_back(e);
  endtask

  task automatic drain(string tag, int budget);
    int n = 0;
    while ((exp_rsp_q.size() != 0 || exp_grant_q.size() != 0 || ior_request_valid != '0) && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_drain"}, 64'(exp_rsp_q.size() + exp_grant_q.size()), 64'd0);
    repeat (2) cycle();
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    ior_request_valid = '0;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_ia_ready"},  64'(ia_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(ia_response_valid), 64'd0);
    check({tag, "_rsp"},       64'(ia_response), 64'd0);
    check({tag, "_write_en"},  64'(io_bus.write_en), 64'd0);
    check({tag, "_read_en"},   64'(io_bus.read_en), 64'd0);
    check({tag, "_address"},   64'(io_bus.address), 64'd0);
    check({tag, "_wdata"},     64'(io_bus.write_data), 64'd0);
  endtask

  initial begin
    int t0;
    int n;
    int order [5];
    reset             = 1'b1;
    ior_request_valid = '0;
    for (int i = 0; i < N; i++) ior_request[i] = '0;
    io_bus.read_data  = 32'hBAD0_BAD0;

    // Reset values
    repeat (3) cycle();
    check_all_zero("reset");
    reset = 1'b0;
    cycle();

    // Core 1 load, thread 2, addr 0x100 -> DEADBEEF at T+3
    clear_logs();
    request(1, 1'b0, 32'h0000_0100, 32'h0, 2'd2);
    expect_txn(1);
    t0 = cyc;
    drain("load", 20);
    check("load_accept_cyc", 64'(acc_log[0]), 64'(t0));
    check("load_rd_en_cyc",  64'(rd_log[0]), 64'(t0 + 1));
    check("load_rd_en_cnt",  64'(rd_log.size()), 64'd1);
    check("load_addr",       64'(rd_addr_last), 64'h100);
    check("load_rsp_cyc",    64'(rsp_log[0]), 64'(t0 + 3));

    // Core 0 store addr 0x40 value 0x1234 -> response T+2, no read_en
    clear_logs();
    request(0, 1'b1, 32'h0000_0040, 32'h0000_1234, 2'd0);
    expect_txn(0);
    t0 = cyc;
    drain("store", 20);
    check("store_wr_en_cyc", 64'(wr_log[0]), 64'(t0 + 1));
    check("store_wr_en_cnt", 64'(wr_log.size()), 64'd1);
    check("store_addr",      64'(wr_addr_last), 64'h40);
    check("store_wdata",     64'(wr_data_last), 64'h1234);
    check("store_rsp_cyc",   64'(rsp_log[0]), 64'(t0 + 2));
    check("store_no_rd_en",  64'(rd_log.size()), 64'd0);

    // All four cores hold valid continuously
    do_reset(2);
    clear_logs();
    hold_mode = 1'b1;
    for (int c = 0; c < N; c++) request(c, 1'b0, 32'h0000_0200 + 32'(c * 16), 32'h0, 2'(c));
`ifdef IO_ARB_ROUND_ROBIN_EN
    order = '{0, 1, 2, 3, 0};
`else
    order = '{0, 0, 0, 0, 0};
`endif
    for (int k = 0; k < 5; k++) expect_txn(order[k]);
    n = 0;
    while (accept_count < 5 && n < 40) begin
      cycle();
      n++;
    end
    hold_mode = 1'b0;
    ior_request_valid = '0;
    drain("hold4", 40);
    check("hold4_accepts", 64'(acc_log.size()), 64'd5);
    check("hold4_span",    64'(acc_log[4] - acc_log[0]), 64'd16);

    // Core 3 arrives during core 0's CAPTURE
    clear_logs();
    request(0, 1'b0, 32'h0000_0300, 32'h0, 2'd1);
    expect_txn(0);
    t0 = cyc;
    cycle();
    cycle();
    request(3, 1'b0, 32'h0000_0340, 32'h0, 2'd3);
    expect_txn(3);
    drain("busy", 30);
    check("busy_acc0_cyc", 64'(acc_log[0]), 64'(t0));
    check("busy_rsp0_cyc", 64'(rsp_log[0]), 64'(t0 + 3));
    check("busy_acc3_cyc", 64'(acc_log[1]), 64'(t0 + 4));

    // Reset asserted while in CAPTURE
    clear_logs();
    request(2, 1'b0, 32'h0000_0380, 32'h0, 2'd1);
    exp_grant_q.push_back(2);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_all_zero("midrst");
    repeat (3) cycle();
    check("midrst_no_rsp", 64'(rsp_log.size()), 64'd0);
    // Pointer back at 0: core 1 must win over core 3
    request(3, 1'b0, 32'h0000_03C0, 32'h0, 2'd2);
    request(1, 1'b1, 32'h0000_0044, 32'h0000_5678, 2'd3);
    expect_txn(1);
    expect_txn(3);
    drain("postrst", 30);

    // Back-to-back loads from one core
    clear_logs();
    hold_mode = 1'b1;
    request(2, 1'b0, 32'h0000_0400, 32'h0, 2'd0);
    for (int k = 0; k < 3; k++) expect_txn(2);
    n = 0;
    while (accept_count < 3 && n < 30) begin
      cycle();
      n++;
    end
    hold_mode = 1'b0;
    ior_request_valid = '0;
    drain("b2b", 30);
    check("b2b_gap1",   64'(acc_log[1] - acc_log[0]), 64'd4);
    check("b2b_gap2",   64'(acc_log[2] - acc_log[1]), 64'd4);
    check("b2b_rd_cnt", 64'(rd_log.size()), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
